// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB master bridge, one APB transfer per
// accepted AHB transfer, with three AHB wait states when PREADY is tied high.
// Optional feature: define APB_TIMEOUT_EN to add a 4-bit ACCESS timeout that
// ends a stalled transfer with a two-cycle AHB ERROR response.
module ahb_apb_bridge #(
   parameter int XLEN  = 64,
   parameter int ADDRW = 16
) (
   input  logic               clk,
   input  logic               reset,
   // AHB-Lite slave side
   input  logic               HSEL,
   input  logic [ADDRW-1:0]   HADDR,
   input  logic [1:0]         HTRANS,
   input  logic               HWRITE,
   input  logic [2:0]         HSIZE,
   input  logic               HREADY,
   input  logic [XLEN-1:0]    HWDATA,
   output logic [XLEN-1:0]    HRDATA,
   output logic               HREADYOUT,
   output logic               HRESP,
   // APB master side
   output logic               PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output logic [ADDRW-1:0]   PADDR,
   output logic [XLEN-1:0]    PWDATA,
   output logic [XLEN/8-1:0]  PSTRB,
   input  logic [XLEN-1:0]    PRDATA,
   input  logic               PREADY
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3
`ifdef APB_TIMEOUT_EN
      ,
      ERR1   = 3'd4,
      ERR2   = 3'd5
`endif
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              can_accept;
   logic              accept;
   logic              err_resp;
   logic [NB-1:0]     size_mask;
   logic [NB-1:0]     strobe;
   logic [ADDRW-1:0]  addr_q;
   logic              write_q;
   logic [NB-1:0]     strb_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;

`ifdef APB_TIMEOUT_EN
   logic [3:0]        tmo_cnt;

   // ACCESS stall counter: cleared while entering ACCESS, counts PREADY=0 cycles
   always_ff @(posedge clk) begin
      if (reset)
         tmo_cnt <= '0;
      else if (state == SETUP)
         tmo_cnt <= '0;
      else if (state == ACCESS && !PREADY)
         tmo_cnt <= tmo_cnt + 4'd1;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic and state-decoded handshake outputs
   always_comb begin
      next_state = state;
      can_accept = 1'b0;
      HREADYOUT  = 1'b1;
      PSEL       = 1'b0;
      PENABLE    = 1'b0;
      err_resp   = 1'b0;
      case (state)
         IDLE: begin
            can_accept = 1'b1;
         end
         LATCH: begin
            HREADYOUT  = 1'b0;
            next_state = SETUP;
         end
         SETUP: begin
            HREADYOUT  = 1'b0;
            PSEL       = 1'b1;
            next_state = ACCESS;
         end
         ACCESS: begin
            HREADYOUT = 1'b0;
            PSEL      = 1'b1;
            PENABLE   = 1'b1;
            if (PREADY)
               next_state = IDLE;
`ifdef APB_TIMEOUT_EN
            else if (tmo_cnt == 4'hF)
               next_state = ERR1;
`endif
         end
`ifdef APB_TIMEOUT_EN
         ERR1: begin
            HREADYOUT  = 1'b0;
            err_resp   = 1'b1;
            next_state = ERR2;
         end
         ERR2: begin
            err_resp   = 1'b1;
            can_accept = 1'b1;
            next_state = IDLE;
         end
`endif
         default: begin
            next_state = IDLE;
         end
      endcase
      // NONSEQ and SEQ are the only transfer types that start a transfer
      accept = can_accept && HSEL && HREADY &&
               (HTRANS == 2'b10 || HTRANS == 2'b11);
      if (accept)
         next_state = LATCH;
   end

   // Byte-lane strobe from HSIZE at the address offset; oversize enables all lanes
   always_comb begin
      size_mask = '0;
      case (HSIZE)
         3'd0:    size_mask = NB'(1);
         3'd1:    size_mask = NB'(3);
         3'd2:    size_mask = NB'(15);
         default: size_mask = '1;
      endcase
      if (HSIZE >= 3'(OFFW))
         strobe = '1;
      else
         strobe = size_mask << HADDR[OFFW-1:0];
   end

   // Transfer capture, write-data latch and read-data return
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         strb_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            strb_q  <= HWRITE ? strobe : '0;
         end
         if (state == LATCH)
            wdata_q <= HWDATA;
         if (state == ACCESS && PREADY)
            rdata_q <= PRDATA;
      end
   end

   assign PADDR  = addr_q;
   assign PWRITE = write_q;
   assign PSTRB  = strb_q;
   assign PWDATA = wdata_q;
   assign HRDATA = rdata_q;
   assign HRESP  = err_resp;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed vectors for ahb_apb_bridge (XLEN=64 and XLEN=32
// instances driven in lock-step). Timeout vectors follow APB_TIMEOUT_EN.
module tb_ahb_apb_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        hsel, hwrite, hready, pready;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [15:0] haddr;
   logic [63:0] hwdata, prdata;
   logic [63:0] hrdata, pwdata;
   logic        hreadyout, hresp, psel, penable, pwrite;
   logic [15:0] paddr;
   logic [7:0]  pstrb;

   logic [15:0] haddr32;
   logic [2:0]  hsize32;
   logic [31:0] hrdata32, pwdata32;
   logic        hreadyout32, hresp32, psel32, penable32, pwrite32;
   logic [15:0] paddr32;
   logic [3:0]  pstrb32;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ahb_apb_bridge #(.XLEN(64), .ADDRW(16)) u_dut (
      .clk(clk), .reset(reset),
      .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
      .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
      .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
      .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready)
   );

   ahb_apb_bridge #(.XLEN(32), .ADDRW(16)) u_dut32 (
      .clk(clk), .reset(reset),
      .HSEL(hsel), .HADDR(haddr32), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize32), .HREADY(hready), .HWDATA(hwdata[31:0]),
      .HRDATA(hrdata32), .HREADYOUT(hreadyout32), .HRESP(hresp32),
      .PSEL(psel32), .PENABLE(penable32), .PWRITE(pwrite32), .PADDR(paddr32),
      .PWDATA(pwdata32), .PSTRB(pstrb32), .PRDATA(32'h0), .PREADY(pready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [15:0] a, input logic w, input logic [2:0] s);
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = w;
      hsize  = s;
   endtask

   task automatic idle_bus();
      htrans = 2'b00;
   endtask

   initial begin
      reset = 1'b1; hsel = 1'b1; htrans = 2'b10; hready = 1'b1; pready = 1'b1;
      hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0; prdata = '0;
      haddr32 = '0; hsize32 = 3'd0;

      // reset held 2 cycles with a NONSEQ request pending
      tick();
      check("rst1_psel", psel, 1'b0);
      check("rst1_hreadyout", hreadyout, 1'b1);
      tick();
      check("rst_hreadyout", hreadyout, 1'b1);
      check("rst_hresp", hresp, 1'b0);
      check("rst_psel", psel, 1'b0);
      check("rst_penable", penable, 1'b0);
      check("rst_pwrite", pwrite, 1'b0);
      check("rst_paddr", paddr, 16'h0);
      check("rst_pstrb", pstrb, 8'h00);
      check("rst_pwdata", pwdata, 64'h0);
      check("rst_hrdata", hrdata, 64'h0);
      check("rst_psel32", psel32, 1'b0);
      reset = 1'b0;
      idle_bus();
      tick();
      check("idle_psel", psel, 1'b0);

      // dword write, PREADY high: LATCH, SETUP, ACCESS, completion
      addr_phase(16'h4000, 1'b1, 3'd3);
      haddr32 = 16'h4000; hsize32 = 3'd3;
      tick();
      check("w64_latch_hreadyout", hreadyout, 1'b0);
      check("w64_latch_psel", psel, 1'b0);
      idle_bus();
      hwdata = 64'h0123456789ABCDEF;
      tick();
      check("w64_setup_psel", psel, 1'b1);
      check("w64_setup_penable", penable, 1'b0);
      check("w64_setup_paddr", paddr, 16'h4000);
      check("w64_setup_pwrite", pwrite, 1'b1);
      check("w64_setup_pstrb", pstrb, 8'hFF);
      check("w64_setup_pwdata", pwdata, 64'h0123456789ABCDEF);
      check("w64_setup_hreadyout", hreadyout, 1'b0);
      check("w32_dword_pstrb", pstrb32, 4'hF);
      hwdata = 64'h0;
      tick();
      check("w64_access_psel", psel, 1'b1);
      check("w64_access_penable", penable, 1'b1);
      check("w64_access_hreadyout", hreadyout, 1'b0);
      check("w64_access_pwdata", pwdata, 64'h0123456789ABCDEF);
      tick();
      check("w64_done_hreadyout", hreadyout, 1'b1);
      check("w64_done_hresp", hresp, 1'b0);
      check("w64_done_psel", psel, 1'b0);

      // BUSY and HREADY=0 do not start a transfer
      htrans = 2'b01;
      tick(); tick();
      check("busy_psel", psel, 1'b0);
      check("busy_hreadyout", hreadyout, 1'b1);
      htrans = 2'b10; hready = 1'b0;
      tick(); tick();
      check("nohready_psel", psel, 1'b0);
      hready = 1'b1; idle_bus();

      // byte write at offset 5 (64-bit) and half write at BFFE (32-bit)
      addr_phase(16'h0005, 1'b1, 3'd0);
      haddr32 = 16'hBFFE; hsize32 = 3'd1;
      tick();
      idle_bus();
      hwdata = 64'h0000_AA00_0000_0000;
      tick();
      check("wbyte_pstrb", pstrb, 8'h20);
      check("whalf32_pstrb", pstrb32, 4'hC);
      check("whalf32_paddr", paddr32, 16'hBFFE);
      tick(); tick();
      check("wbyte_done_hreadyout", hreadyout, 1'b1);

      // back-to-back reads BFF8 then 0000
      addr_phase(16'hBFF8, 1'b0, 3'd3);
      haddr32 = 16'h0000; hsize32 = 3'd2;
      tick();
      idle_bus();
      prdata = 64'h55;
      tick();
      check("rd1_pstrb", pstrb, 8'h00);
      check("rd1_pwrite", pwrite, 1'b0);
      check("rd1_paddr", paddr, 16'hBFF8);
      addr_phase(16'h0000, 1'b0, 3'd3);
      tick();
      check("rd1_access_penable", penable, 1'b1);
      tick();
      check("rd1_done_hrdata", hrdata, 64'h55);
      check("rd1_done_hreadyout", hreadyout, 1'b1);
      check("rd1_done_psel", psel, 1'b0);
      prdata = 64'h1;
      tick();
      check("rd2_latch_hreadyout", hreadyout, 1'b0);
      check("rd2_latch_hrdata_hold", hrdata, 64'h55);
      idle_bus();
      tick();
      check("rd2_setup_psel", psel, 1'b1);
      check("rd2_setup_paddr", paddr, 16'h0000);
      tick(); tick();
      check("rd2_done_hrdata", hrdata, 64'h1);
      check("rd2_done_hreadyout", hreadyout, 1'b1);

      // write with 3 ACCESS wait cycles (word at offset 4)
      pready = 1'b0;
      addr_phase(16'h1234, 1'b1, 3'd2);
      tick();
      idle_bus();
      tick();
      check("wwait_pstrb", pstrb, 8'hF0);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("wwait_penable", penable, 1'b1);
         check("wwait_hreadyout", hreadyout, 1'b0);
         tick();
      end
      check("wwait_still_access", penable, 1'b1);
      pready = 1'b1;
      tick();
      check("wwait_done_hreadyout", hreadyout, 1'b1);
      check("wwait_done_psel", psel, 1'b0);

      // read with PREADY stuck low
      pready = 1'b0;
      prdata = 64'hDEAD;
      addr_phase(16'h2000, 1'b0, 3'd3);
      tick();
      idle_bus();
      tick(); tick();
`ifdef APB_TIMEOUT_EN
      repeat (15) tick();
      check("tmo_access16_penable", penable, 1'b1);
      check("tmo_access16_hresp", hresp, 1'b0);
      tick();
      check("tmo_err1_hresp", hresp, 1'b1);
      check("tmo_err1_hreadyout", hreadyout, 1'b0);
      check("tmo_err1_psel", psel, 1'b0);
      tick();
      check("tmo_err2_hresp", hresp, 1'b1);
      check("tmo_err2_hreadyout", hreadyout, 1'b1);
      check("tmo_err2_hrdata", hrdata, 64'h1);
      tick();
      check("tmo_idle_hresp", hresp, 1'b0);
      check("tmo_idle_hreadyout", hreadyout, 1'b1);
      pready = 1'b1;
`else
      repeat (20) tick();
      check("stall_penable", penable, 1'b1);
      check("stall_hresp", hresp, 1'b0);
      check("stall_hreadyout", hreadyout, 1'b0);
      pready = 1'b1;
      tick();
      check("stall_done_hreadyout", hreadyout, 1'b1);
      check("stall_done_hrdata", hrdata, 64'hDEAD);
`endif

      // reset during ACCESS drops the transfer
      pready = 1'b0;
      addr_phase(16'h3000, 1'b1, 3'd3);
      tick();
      idle_bus();
      hwdata = 64'h1111_2222_3333_4444;
      tick(); tick();
      check("rsta_penable", penable, 1'b1);
      reset = 1'b1;
      tick();
      check("rsta_psel", psel, 1'b0);
      check("rsta_penable_low", penable, 1'b0);
      check("rsta_hreadyout", hreadyout, 1'b1);
      check("rsta_paddr", paddr, 16'h0);
      check("rsta_pwdata", pwdata, 64'h0);
      check("rsta_hrdata", hrdata, 64'h0);

      // first acceptance on the first edge with reset low
      reset = 1'b0;
      pready = 1'b1;
      addr_phase(16'h0008, 1'b0, 3'd2);
      tick();
      check("post_rst_latch_hreadyout", hreadyout, 1'b0);
      idle_bus();
      tick();
      check("post_rst_psel", psel, 1'b1);
      check("post_rst_paddr", paddr, 16'h0008);
      tick(); tick();
      check("post_rst_done_hreadyout", hreadyout, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 Parameter XLEN, default 64, sets data bus width; the only legal values are 32 and 64.
REQ-002 Parameter ADDRW, default 16, sets the APB address width.
REQ-003 Port clk, input, 1, the single clock for all logic.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Ports on the AHB-Lite slave side, all inputs: HSEL 1, HADDR ADDRW, HTRANS 2, HWRITE 1, HSIZE 3, HREADY 1, HWDATA XLEN.
REQ-006 Ports on the AHB-Lite slave side, all outputs: HRDATA XLEN, HREADYOUT 1, HRESP 1.
REQ-007 Ports on the APB master side, all outputs: PSEL 1, PENABLE 1, PWRITE 1, PADDR ADDRW, PWDATA XLEN, PSTRB XLEN/8.
REQ-008 Ports on the APB master side, all inputs: PRDATA XLEN, PREADY 1.

Function
REQ-009 The FSM states are IDLE, LATCH, SETUP, ACCESS, ERR1 and ERR2; the state is registered.
REQ-010 A transfer is accepted when all of the following hold at a rising edge: HSEL=1, HTRANS[1]=1, HREADY=1, and the state is IDLE or the current transfer completes in this cycle.
- On acceptance the bridge captures HADDR, HWRITE and HSIZE and moves to LATCH.
REQ-011 When HTRANS is IDLE or BUSY, or HSEL=0, no capture occurs and the state is unaffected.
REQ-012 In LATCH the bridge registers HWDATA into PWDATA and holds HREADYOUT=0.
- The next state is SETUP.
REQ-013 In SETUP: PSEL=1, PENABLE=0, and PADDR/PWRITE/PWDATA/PSTRB are stable.
- The next state is ACCESS.
REQ-014 In ACCESS: PSEL=1 and PENABLE=1.
- If PREADY=0, the bridge stays in ACCESS with all APB outputs held.
- If PREADY=1, HRDATA<=PRDATA and the next state is IDLE.
REQ-015 HREADYOUT=0 from the cycle after acceptance until the cycle after the ACCESS cycle in which PREADY=1; in that cycle HREADYOUT=1 and HRESP=0.
REQ-016 With PREADY tied high, the AHB data phase is exactly 4 cycles (3 wait states).
REQ-017 Back-to-back transfers: a transfer accepted in the completing cycle goes directly to LATCH with no idle cycle.
- HRDATA for the completed read stays valid for that cycle.
REQ-018 PSTRB on writes:
- lanes are selected by HSIZE (0 = byte, 1 = half, 2 = word, 3 = dword) at the offset HADDR[2:0] when XLEN=64, or HADDR[1:0] when XLEN=32;
- an HSIZE wider than XLEN/8 bytes enables all lanes.
REQ-019 PSTRB on reads is all zeros.
REQ-020 PSEL=0 and PENABLE=0 in IDLE, LATCH, ERR1 and ERR2.
REQ-021 HRDATA holds its last value except when it is updated per REQ-014.

Reset
REQ-022 When reset=1 at a rising edge, the state becomes IDLE regardless of any transfer in flight.
- After that edge: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, HRDATA=0, and the timeout counter is 0.
REQ-023 A transfer interrupted by reset is dropped and no completion is signalled.
- The first acceptance is possible on the first edge with reset=0.

Configuration
REQ-024 Macro APB_TIMEOUT_EN, when defined, adds a 4-bit counter.
- The counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
- When it reaches 15 with PREADY still 0, the next state is ERR1.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Then IDLE.
- HRDATA is unchanged on the error path.
- A new transfer may be accepted in ERR2.
REQ-025 Without APB_TIMEOUT_EN, the counter and the ERR1/ERR2 states are absent.
- ACCESS waits indefinitely for PREADY, and HRESP is constant 0.

Verification
REQ-026 Reset: hold reset=1 for 2 cycles with HSEL=1 and HTRANS=2'b10 -> HREADYOUT=1, PSEL=0, and no APB activity.
REQ-027 XLEN=64 write: HADDR=16'h4000, HSIZE=3, HWDATA=64'h0123456789ABCDEF, PREADY=1.
- SETUP appears 2 cycles after acceptance with PADDR=16'h4000, PWRITE=1, PSTRB=8'hFF.
- HREADYOUT=1 in the 4th data-phase cycle.
REQ-028 XLEN=64 byte write: HADDR=16'h0005, HSIZE=0 -> PSTRB=8'h20.
- XLEN=32 half write: HADDR=16'hBFFE, HSIZE=1 -> PSTRB=4'hC.
REQ-029 Back-to-back read 16'hBFF8 followed by read 16'h0000, with PRDATA=64'h55 then 1.
- HRDATA=64'h55 in the first completion cycle.
- The second PSEL rises 2 cycles later.
- No idle cycle occurs between the two transfers.
REQ-030 PREADY held 0 for 3 ACCESS cycles -> PENABLE stays high and HREADYOUT stays low.
- Completion follows one cycle after PREADY=1.
- Reset asserted during ACCESS -> PSEL=0 on the next edge.
REQ-031 With APB_TIMEOUT_EN and PREADY stuck at 0 -> ERR1 after 16 ACCESS cycles, then ERR2 (HRESP=1, HREADYOUT=1), then IDLE.
